// File: rtl/axis_pktgen_pkg.sv
// axis_pktgen_pkg: shared FSM state type and the per-word payload builder for the packet generator
package axis_pktgen_pkg;
  localparam int MAX_DB = 64;
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  typedef struct packed {
    logic [MAX_DB*8-1:0] data;
    logic [MAX_DB-1:0]   keep;
  } word_t;
  function automatic word_t payload_word(input int pkt, input int word, input int db, input int blen);
    word_t w;
    int k;
    w = '0;
    for (int l = 0; l < MAX_DB; l++) begin
      k = word * db + l;
      if (l < db && k < blen) begin
        w.keep[l] = 1'b1;
        w.data[l*8 +: 8] = 8'(pkt + k);
      end
    end
    return w;
  endfunction
endpackage

// File: rtl/AXIS_int.sv
// AXIS_int: AXI-Stream bundle with master/slave views
interface AXIS_int #(
  parameter int DATA_BYTES = 8,
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 4,
  parameter int USER_WIDTH = 1
) ();
  logic                    tvalid;
  logic                    tready;
  logic [DATA_BYTES*8-1:0] tdata;
  logic [DATA_BYTES-1:0]   tkeep;
  logic [DATA_BYTES-1:0]   tstrb;
  logic                    tlast;
  logic [ID_WIDTH-1:0]     tid;
  logic [DEST_WIDTH-1:0]   tdest;
  logic [USER_WIDTH-1:0]   tuser;
  modport Master (output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser, input tready);
  modport Slave  (input tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/axis_packet_generator.sv
// axis_packet_generator: emits counted runs of fixed-length AXI-Stream packets with optional idle gaps
module axis_packet_generator
  import axis_pktgen_pkg::*;
#(
  parameter int DATA_BYTES = 8,
  parameter int DEST_WIDTH = 4,
  parameter int MTU_BYTES  = 1500,
  parameter int MAX_PKTS   = 65535
) (
  input  logic                           clk,
  input  logic                           sreset,
  input  logic                           start,
  input  logic [$clog2(MAX_PKTS+1)-1:0]  num_pkts,
  input  logic [$clog2(MTU_BYTES+1)-1:0] pkt_blen,
  input  logic [DEST_WIDTH-1:0]          pkt_dest,
  input  logic                           dest_incr,
  input  logic [15:0]                    gap_cycles,
  output logic                           busy,
  output logic                           done,
  output logic                           cfg_err,
  output logic [$clog2(MAX_PKTS+1)-1:0]  pkts_sent,
  AXIS_int.Master                        axis_out
);
  localparam int NP_W = $clog2(MAX_PKTS + 1);
  localparam int BL_W = $clog2(MTU_BYTES + 1);
  localparam int WW   = $clog2((MTU_BYTES + DATA_BYTES - 1) / DATA_BYTES + 1);
  localparam int DW   = DATA_BYTES * 8;
  state_t                state_q, state_d;
  logic [NP_W-1:0]       num_q, num_d, pkts_q, pkts_d, lp;
  logic [BL_W-1:0]       blen_q, blen_d, lb;
  logic                  incr_q, incr_d;
  logic [15:0]           gap_q, gap_d, gcnt_q, gcnt_d;
  logic [WW-1:0]         word_q, word_d, lw;
  logic                  tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic [DW-1:0]         tdata_q, tdata_d;
  logic [DATA_BYTES-1:0] tkeep_q, tkeep_d;
  logic [DEST_WIDTH-1:0] tdest_q, tdest_d;
  logic                  done_q, done_d, cfg_err_q, cfg_err_d;
  logic                  hs, cfg_ok, ld, lastw, unused_pw;
  word_t                 pw;
  assign hs = tvalid_q & axis_out.tready;
  assign cfg_ok = pkt_blen != '0 && pkt_blen <= BL_W'(MTU_BYTES);
  // pick which (packet, word, length) the next loaded beat is built from
  always_comb begin
    lp = state_q == IDLE ? '0 : (state_q == SEND && tlast_q) ? pkts_q + 1'b1 : pkts_q;
    lw = (state_q == SEND && !tlast_q) ? word_q + 1'b1 : '0;
    lb = state_q == IDLE ? pkt_blen : blen_q;
  end
  assign pw = payload_word(int'(lp), int'(lw), DATA_BYTES, int'(lb));
  assign lastw = (int'(lw) + 1) * DATA_BYTES >= int'(lb);
  assign unused_pw = ^pw;
  // run sequencing: accept/reject start, advance words and packets, count gaps
  always_comb begin
    state_d = state_q;
    num_d = num_q;
    blen_d = blen_q;
    incr_d = incr_q;
    gap_d = gap_q;
    pkts_d = pkts_q;
    word_d = word_q;
    gcnt_d = gcnt_q;
    tvalid_d = tvalid_q;
    tlast_d = tlast_q;
    tdata_d = tdata_q;
    tkeep_d = tkeep_q;
    tdest_d = tdest_q;
    done_d = 1'b0;
    cfg_err_d = 1'b0;
    ld = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (!cfg_ok) cfg_err_d = 1'b1;
        else begin
          num_d = num_pkts;
          blen_d = pkt_blen;
          incr_d = dest_incr;
          gap_d = gap_cycles;
          pkts_d = '0;
          tdest_d = pkt_dest;
          if (num_pkts == '0) done_d = 1'b1;
          else begin
            state_d = SEND;
            ld = 1'b1;
          end
        end
      end
      SEND: if (hs) begin
        if (!tlast_q) ld = 1'b1;
        else begin
          pkts_d = pkts_q + 1'b1;
          tdest_d = tdest_q + DEST_WIDTH'(incr_q);
          if (pkts_d == num_q) begin
            state_d = IDLE;
            tvalid_d = 1'b0;
            tlast_d = 1'b0;
            done_d = 1'b1;
          end else if (gap_q == '0) ld = 1'b1;
          else begin
            state_d = GAP;
            tvalid_d = 1'b0;
            tlast_d = 1'b0;
            gcnt_d = gap_q;
          end
        end
      end
      GAP: if (gcnt_q == 16'd1) begin
        state_d = SEND;
        ld = 1'b1;
      end else gcnt_d = gcnt_q - 1'b1;
      default: state_d = IDLE;
    endcase
    if (ld) begin
      tvalid_d = 1'b1;
      word_d = lw;
      tdata_d = pw.data[DW-1:0];
      tkeep_d = pw.keep[DATA_BYTES-1:0];
      tlast_d = lastw;
    end
  end
  // state and registered stream outputs
  always_ff @(posedge clk) begin
    if (sreset) begin
      state_q <= IDLE;
      num_q <= '0;
      blen_q <= '0;
      incr_q <= 1'b0;
      gap_q <= '0;
      pkts_q <= '0;
      word_q <= '0;
      gcnt_q <= '0;
      tvalid_q <= 1'b0;
      tlast_q <= 1'b0;
      tdata_q <= '0;
      tkeep_q <= '0;
      tdest_q <= '0;
      done_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q <= num_d;
      blen_q <= blen_d;
      incr_q <= incr_d;
      gap_q <= gap_d;
      pkts_q <= pkts_d;
      word_q <= word_d;
      gcnt_q <= gcnt_d;
      tvalid_q <= tvalid_d;
      tlast_q <= tlast_d;
      tdata_q <= tdata_d;
      tkeep_q <= tkeep_d;
      tdest_q <= tdest_d;
      done_q <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign cfg_err = cfg_err_q;
  assign pkts_sent = pkts_q;
  assign axis_out.tvalid = tvalid_q;
  assign axis_out.tdata = tdata_q;
  assign axis_out.tkeep = tkeep_q;
  assign axis_out.tstrb = tkeep_q;
  assign axis_out.tlast = tlast_q;
  assign axis_out.tdest = tdest_q;
  assign axis_out.tid = '0;
  assign axis_out.tuser = '0;
endmodule

// File: tb/tb_axis_packet_generator.sv
// tb_axis_packet_generator: table-driven and random-stall checks of the packet generator against a queue model
module tb_axis_packet_generator;
  import axis_pktgen_pkg::*;
  typedef struct {
    int num, blen, dest;
    bit incr;
    int gap, pct, beats;
    logic [7:0] lkeep;
    bit err;
  } vec_t;
  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic [3:0]  dst;
  } beat_t;
  logic clk = 0, sreset = 1, start = 0, dest_incr = 0;
  logic [15:0] num_pkts = 0, gap_cycles = 0;
  logic [10:0] pkt_blen = 0;
  logic [3:0] pkt_dest = 0;
  logic busy, done, cfg_err;
  logic [15:0] pkts_sent;
  int n_checks = 0, n_fail = 0, ready_pct = 100;
  beat_t expq[$];
  vec_t vecs[9];
  AXIS_int #(.DATA_BYTES(8), .ID_WIDTH(1), .DEST_WIDTH(4), .USER_WIDTH(1)) axis ();
  axis_packet_generator #(.DATA_BYTES(8), .DEST_WIDTH(4), .MTU_BYTES(1500), .MAX_PKTS(65535)) dut (
    .clk(clk), .sreset(sreset), .start(start), .num_pkts(num_pkts), .pkt_blen(pkt_blen),
    .pkt_dest(pkt_dest), .dest_incr(dest_incr), .gap_cycles(gap_cycles), .busy(busy),
    .done(done), .cfg_err(cfg_err), .pkts_sent(pkts_sent), .axis_out(axis)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
    axis.tready = ($urandom_range(99) < ready_pct);
  endtask
  task automatic model(input vec_t v);
    int words;
    word_t pw;
    beat_t b;
    words = (v.blen + 7) / 8;
    for (int n = 0; n < v.num; n++)
      for (int w = 0; w < words; w++) begin
        pw = payload_word(n, w, 8, v.blen);
        b.d = pw.data[63:0];
        b.k = pw.keep[7:0];
        b.l = (w == words - 1);
        b.dst = 4'(v.dest + (v.incr ? n : 0));
        expq.push_back(b);
      end
  endtask
  task automatic start_cfg(input vec_t v);
    num_pkts = 16'(v.num);
    pkt_blen = 11'(v.blen);
    pkt_dest = 4'(v.dest);
    dest_incr = v.incr;
    gap_cycles = 16'(v.gap);
    start = 1;
    step();
    start = 0;
    num_pkts = 16'($urandom);
    pkt_blen = 11'($urandom);
    pkt_dest = 4'($urandom);
    dest_incr = 1'($urandom);
    gap_cycles = 16'($urandom);
  endtask
  task automatic finish_run(input vec_t v);
    int beats = 0, pk = 0, lowrun = 0;
    bit in_gap = 0, fin = 0, final_pending = 0, stalled = 0, sop = 1;
    logic [87:0] prev = '0, cur;
    logic [7:0] lastk = 0;
    beat_t e;
    for (int c = 0; c < 6000; c++) begin
      cur = {axis.tvalid, axis.tdata, axis.tkeep, axis.tstrb, axis.tlast, axis.tdest, axis.tid, axis.tuser};
      if (final_pending) begin
        chk("done_pulse", done, 1);
        chk("busy_end", busy, 0);
        chk("tvalid_end", axis.tvalid, 0);
        chk("pkts_sent", pkts_sent, v.num);
        fin = 1;
        break;
      end
      if (stalled) chk("stall_hold", cur, prev);
      if (axis.tvalid) begin
        if (in_gap) begin
          chk("gap_len", lowrun, v.gap);
          in_gap = 0;
        end
        if (axis.tready) begin
          if (expq.size() == 0) chk("extra_beat", axis.tvalid, 0);
          else begin
            e = expq.pop_front();
            chk("beat", cur[86:0], {e.d, e.k, e.k, e.l, e.dst, 2'b00});
          end
          if (sop && pk == 1) chk("p1_byte0", axis.tdata[7:0], 8'h01);
          sop = axis.tlast;
          beats++;
          if (axis.tlast) begin
            pk++;
            lastk = axis.tkeep;
            if (pk == v.num) final_pending = 1;
            else begin
              in_gap = 1;
              lowrun = 0;
            end
          end
        end
      end else if (in_gap) lowrun++;
      else chk("tvalid_drop", axis.tvalid, 1);
      stalled = axis.tvalid && !axis.tready;
      prev = cur;
      step();
    end
    if (!fin) chk("run_timeout", done, 1);
    else begin
      step();
      chk("done_once", done, 0);
      chk("pkts_hold", pkts_sent, v.num);
    end
    chk("beats", beats, v.beats);
    if (beats > 0) chk("last_keep", lastk, v.lkeep);
    chk("exp_left", expq.size(), 0);
    expq.delete();
  endtask
  task automatic run_vec(input vec_t v);
    ready_pct = v.pct;
    if (!v.err && v.num > 0) model(v);
    start_cfg(v);
    if (v.err) begin
      chk("cfg_err_pulse", cfg_err, 1);
      chk("cfg_err_busy", busy, 0);
      step();
      chk("cfg_err_once", cfg_err, 0);
      chk("cfg_err_idle", {busy, axis.tvalid}, 2'b00);
    end else if (v.num == 0) begin
      chk("zero_done", done, 1);
      chk("zero_tvalid", axis.tvalid, 0);
      chk("zero_pkts", pkts_sent, 0);
      chk("zero_busy", busy, 0);
      step();
      chk("zero_after", {done, axis.tvalid}, 2'b00);
    end else begin
      chk("first_valid", {axis.tvalid, busy}, 2'b11);
      finish_run(v);
    end
  endtask
  initial begin
    vec_t v;
    int r;
    vecs[0] = '{3, 20, 2, 1'b1, 0, 100, 9, 8'h0F, 1'b0};
    vecs[1] = '{3, 16, 0, 1'b0, 5, 100, 6, 8'hFF, 1'b0};
    vecs[2] = '{2, 1, 7, 1'b1, 0, 100, 2, 8'h01, 1'b0};
    vecs[3] = '{1, 1500, 3, 1'b0, 0, 100, 188, 8'h0F, 1'b0};
    vecs[4] = '{100, 37, 14, 1'b1, 2, 30, 500, 8'h1F, 1'b0};
    vecs[5] = '{0, 8, 1, 1'b0, 0, 100, 0, 8'h00, 1'b0};
    vecs[6] = '{2, 0, 1, 1'b0, 0, 100, 0, 8'h00, 1'b1};
    vecs[7] = '{2, 1501, 1, 1'b0, 0, 100, 0, 8'h00, 1'b1};
    vecs[8] = '{4, 64, 15, 1'b0, 1, 50, 32, 8'hFF, 1'b0};
    axis.tready = 1;
    repeat (3) step();
    chk("rst_ctrl", {busy, done, cfg_err, axis.tvalid, axis.tlast}, 5'b0);
    chk("rst_data", {axis.tdata, axis.tkeep, axis.tstrb, axis.tdest}, 84'b0);
    chk("rst_pkts", pkts_sent, 0);
    sreset = 0;
    for (int i = 0; i < 9; i++) run_vec(vecs[i]);
    v = '{2, 16, 5, 1'b1, 0, 100, 4, 8'hFF, 1'b0};
    model(v);
    ready_pct = 0;
    start_cfg(v);
    chk("busy_first", {axis.tvalid, busy}, 2'b11);
    step();
    start = 1;
    pkt_blen = 0;
    num_pkts = 7;
    step();
    start = 0;
    chk("busy_start_err", cfg_err, 0);
    chk("busy_start_busy", busy, 1);
    step();
    chk("busy_start_err2", cfg_err, 0);
    ready_pct = v.pct;
    finish_run(v);
    v = '{1, 40, 6, 1'b0, 0, 100, 5, 8'hFF, 1'b0};
    ready_pct = 100;
    start_cfg(v);
    step();
    step();
    chk("w2_byte0", axis.tdata[7:0], 8'd16);
    chk("w2_nolast", {axis.tvalid, axis.tlast}, 2'b10);
    sreset = 1;
    step();
    chk("rst_mid", {axis.tvalid, axis.tlast, busy}, 3'b000);
    chk("rst_mid_pkts", pkts_sent, 0);
    sreset = 0;
    run_vec('{2, 40, 9, 1'b0, 1, 100, 10, 8'hFF, 1'b0});
    for (int i = 0; i < 4; i++) begin
      v.num = $urandom_range(1, 6);
      v.blen = $urandom_range(1, 200);
      v.dest = $urandom_range(0, 15);
      v.incr = 1'($urandom);
      v.gap = $urandom_range(0, 3);
      v.pct = $urandom_range(30, 100);
      v.err = 0;
      v.beats = v.num * ((v.blen + 7) / 8);
      r = v.blen % 8;
      v.lkeep = r == 0 ? 8'hFF : 8'((1 << r) - 1);
      run_vec(v);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/axis_packet_generator.md
AXIS_PACKET_GENERATOR -- requirements
Module: axis_packet_generator

Interface
REQ-001 Parameters SHALL be, one per line: DATA_BYTES, 8, stream width in bytes; DEST_WIDTH, 4, tdest width; MTU_BYTES, 1500, maximum packet byte length; MAX_PKTS, 65535, maximum packet count per run.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be, one per line:
- clk  in  1  sole clock.
- sreset  in  1  synchronous active-high reset.
- start  in  1  one-cycle run request.
- num_pkts  in  clog2(MAX_PKTS+1)  packets per run.
- pkt_blen  in  clog2(MTU_BYTES+1)  byte length of every packet in the run.
- pkt_dest  in  DEST_WIDTH  tdest of packet 0.
- dest_incr  in  1  add 1 to tdest per packet, wrapping at 2^DEST_WIDTH.
- gap_cycles  in  16  idle cycles after each tlast.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at run end.
- cfg_err  out  1  one-cycle pulse when start is rejected.
- pkts_sent  out  clog2(MAX_PKTS+1)  packets completed in the current or last run.
- axis_out  AXIS_int.Master  DATA_BYTES wide, ID_WIDTH/USER_WIDTH of the instantiating interface.

Function
REQ-004 The FSM SHALL have three states, IDLE, SEND and GAP; it enters IDLE on reset.
REQ-005 In IDLE with busy low, start SHALL latch num_pkts, pkt_blen, pkt_dest, dest_incr and gap_cycles. Later input changes SHALL NOT affect the run.
REQ-006 When pkt_blen is 0 or greater than MTU_BYTES, start SHALL pulse cfg_err the next cycle and remain in IDLE.
REQ-007 When num_pkts is 0 and the configuration is valid, start SHALL pulse done the next cycle with no transfer, and pkts_sent SHALL be 0.
REQ-008 Start accepted at cycle N SHALL give tvalid high and busy high at cycle N+1 (state SEND).
REQ-009 Start while busy SHALL be ignored, with no cfg_err.
REQ-010 Once tvalid is high, tvalid, tdata, tkeep, tstrb, tlast and tdest SHALL hold stable until the cycle tvalid and tready are both high.
REQ-011 Byte k of packet n SHALL be (n[7:0] + k) mod 256, at lane k mod DATA_BYTES of word floor(k/DATA_BYTES).
REQ-012 Each packet SHALL be ceil(pkt_blen/DATA_BYTES) words, with tlast on the final word only.
REQ-013 tkeep SHALL be all ones except on the final word, which SHALL have its low (pkt_blen mod DATA_BYTES) bits set, or all ones when that value is 0. Unkept bytes SHALL be 0.
REQ-014 tstrb SHALL equal tkeep; tid and tuser SHALL be 0.
REQ-015 tdest SHALL be pkt_dest + (dest_incr ? n : 0), truncated to DEST_WIDTH.
REQ-016 The tlast handshake SHALL increment pkts_sent in the same cycle edge.
- If packets remain and gap_cycles is 0: state stays SEND and the next packet's first word is valid the following cycle.
- If gap_cycles > 0: go to GAP, with tvalid low for exactly gap_cycles cycles.
REQ-017 The tlast handshake of the final packet SHALL give, in the next cycle, done pulsing high, busy low and tvalid low; the FSM SHALL then be in IDLE. The gap SHALL NOT be applied after the final packet.
REQ-018 pkts_sent SHALL clear to 0 on an accepted start and otherwise hold its value after done.
REQ-019 tready low for any number of cycles SHALL stall without loss; there is no timeout.
REQ-020 Word and byte counters SHALL be sized from MTU_BYTES and DATA_BYTES, and the packet counter from MAX_PKTS, with no wrap within a run.

Reset
REQ-021 While sreset is high, the following SHALL hold at the next edge:
- state IDLE; tvalid, tlast, busy, done and cfg_err all 0.
- tdata, tkeep, tstrb and tdest at 0; pkts_sent 0; latched configuration at 0.
REQ-022 Reset asserted mid-packet SHALL drop tvalid the next cycle with no tlast. Start SHALL be honoured on the first cycle after sreset deasserts.

Structure
REQ-023 Package axis_pktgen_pkg SHALL hold the state enum type and a payload_word function of (pkt index, word index, DATA_BYTES, blen) returning tdata and tkeep. Testbench checkers SHALL use the same function to build expected packets.
REQ-024 The block SHALL be a single module with no sub-module, and the RTL SHALL be synthesizable.

Verification
REQ-025 DATA_BYTES=8, start with num_pkts=3, pkt_blen=20, pkt_dest=2, dest_incr=1, gap_cycles=0, tready=1 -> the bench SHALL observe:
- 9 contiguous beats; tdest 2,3,4.
- Last-word tkeep 0x0F; packet 1 byte 0 is 0x01.
- done at the cycle after the 9th beat; pkts_sent=3.
REQ-026 pkt_blen=16, gap_cycles=5 -> exactly 5 tvalid-low cycles between packets, with none after the last packet.
REQ-027 Random tready at 30% high -> data stable while stalled, and byte-exact match to axis_pktgen_pkg expectations for 100 packets.
REQ-028 Invalid start values -> the bench SHALL observe:
- pkt_blen=0 or 1501: cfg_err pulse, busy stays 0.
- num_pkts=0: done pulse, no tvalid.
- Start while busy: ignored.
REQ-029 sreset raised on word 2 of a 40-byte packet -> tvalid 0 the next cycle, no tlast, pkts_sent 0. A fresh run after reset completes correctly.
REQ-030 pkt_blen=1 and pkt_blen=MTU_BYTES -> single-beat packet with tkeep 0x01, and a 188-beat packet with final tkeep 0x0F, respectively.
